// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - fetch-stage bundle: instruction memory port, redirect input, instruction output handshake.
// master = fetch stage, slave = memory/control/decode side.
interface inst_fetch_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [31:0] pc_plus4;
   logic        fetch_error;
   logic [31:0] fetch_count;

   modport master (
      output imem_addr,
      input  imem_data,
      input  redirect_valid,
      input  redirect_pc,
      output inst_valid,
      input  inst_ready,
      output inst,
      output inst_pc,
      output pc_plus4,
      output fetch_error,
      output fetch_count
   );

   modport slave (
      input  imem_addr,
      output imem_data,
      output redirect_valid,
      output redirect_pc,
      input  inst_valid,
      output inst_ready,
      input  inst,
      input  inst_pc,
      input  pc_plus4,
      input  fetch_error,
      input  fetch_count
   );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - MIPS fetch stage: PC, settle-timed capture into instruction register, redirect and misalignment halt.
// Optional FETCH_COUNT_EN adds a wrapping handshake counter on fetch_count.
module inst_fetch #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int          SETTLE_CYCLES = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   inst_fetch_if.master  io_bus
);

   localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_VALID = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_pc;
   logic [31:0] w_pc_next;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_next;
   logic        w_capture;
   logic [31:0] r_inst;
   logic [31:0] r_inst_pc;
   logic [31:0] r_pc_plus4;
   logic        r_inst_valid;
   logic        r_fetch_error;

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_cnt_next   = r_cnt;
      w_capture    = 1'b0;
      // Redirect overrides everything, including a same-cycle handshake's pc + 4.
      if (io_bus.redirect_valid) begin
         w_pc_next    = io_bus.redirect_pc;
         w_cnt_next   = SETTLE;
         w_state_next = ST_WAIT;
      end else begin
         case (r_state)
            ST_WAIT: begin
               if (r_pc[1:0] != 2'b00) begin
                  w_state_next = ST_ERROR;
               end else if (r_cnt != 4'd0) begin
                  w_cnt_next = r_cnt - 4'd1;
               end else begin
                  w_capture    = 1'b1;
                  w_state_next = ST_VALID;
               end
            end
            ST_VALID: begin
               if (io_bus.inst_ready) begin
                  w_pc_next    = r_pc + 32'd4;
                  w_cnt_next   = SETTLE;
                  w_state_next = ST_WAIT;
               end
            end
            ST_ERROR: begin
               w_state_next = ST_ERROR;
            end
            default: begin
               w_state_next = ST_WAIT;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_WAIT;
         r_pc          <= RESET_PC;
         r_cnt         <= SETTLE;
         r_inst_valid  <= 1'b0;
         r_fetch_error <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_pc          <= w_pc_next;
         r_cnt         <= w_cnt_next;
         r_inst_valid  <= (w_state_next == ST_VALID);
         r_fetch_error <= (w_state_next == ST_ERROR);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inst     <= 32'h0;
         r_inst_pc  <= 32'h0;
         r_pc_plus4 <= 32'd4;
      end else if (w_capture) begin
         r_inst     <= io_bus.imem_data;
         r_inst_pc  <= r_pc;
         r_pc_plus4 <= r_pc + 32'd4;
      end
   end

   assign io_bus.imem_addr   = r_pc;
   assign io_bus.inst        = r_inst;
   assign io_bus.inst_pc     = r_inst_pc;
   assign io_bus.pc_plus4    = r_pc_plus4;
   assign io_bus.inst_valid  = r_inst_valid;
   assign io_bus.fetch_error = r_fetch_error;

`ifdef FETCH_COUNT_EN
   logic        w_handshake;
   logic [31:0] r_fetch_count;

   assign w_handshake = r_inst_valid && io_bus.inst_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_count <= 32'h0;
      end else if (w_handshake) begin
         r_fetch_count <= r_fetch_count + 32'd1;
      end
   end

   assign io_bus.fetch_count = r_fetch_count;
`else
   assign io_bus.fetch_count = 32'h0;
`endif

endmodule
